// File: rtl/ifetch_resp_if.sv
// Fetch-side bus between the PC generator (master) and ifetch_resp (slave).
// IFETCH_MISALIGN_CHK_EN adds misalign_o to the bundle.
interface ifetch_resp_if;
    logic        req_i;
    logic [31:0] pc_i;
    logic        flush_i;
    logic        we_i;
    logic [31:0] waddr_i;
    logic [31:0] wdata_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;
    logic        stall_o;
`ifdef IFETCH_MISALIGN_CHK_EN
    logic        misalign_o;

    modport master (
        output req_i, pc_i, flush_i, we_i, waddr_i, wdata_i,
        input  inst_o, inst_addr_o, inst_valid_o, stall_o, misalign_o
    );
    modport slave (
        input  req_i, pc_i, flush_i, we_i, waddr_i, wdata_i,
        output inst_o, inst_addr_o, inst_valid_o, stall_o, misalign_o
    );
`else
    modport master (
        output req_i, pc_i, flush_i, we_i, waddr_i, wdata_i,
        input  inst_o, inst_addr_o, inst_valid_o, stall_o
    );
    modport slave (
        input  req_i, pc_i, flush_i, we_i, waddr_i, wdata_i,
        output inst_o, inst_addr_o, inst_valid_o, stall_o
    );
`endif
endinterface

// File: rtl/ifetch_resp.sv
// Instruction fetch responder over a word RAM; valid WAIT_CYCLES+1 edges after request.
// Backpressure via stall_o, flush_i aborts; IFETCH_MISALIGN_CHK_EN adds misalign_o.
module ifetch_resp #(
    parameter int          AW          = 10,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] NOP_INST    = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    ifetch_resp_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [2:0] CNT_INIT = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] addr_q;
    logic [31:0] inst_q;
    logic [31:0] inst_addr_q;
    logic [31:0] rd_addr;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;
    logic        load_addr;
    logic        enter_resp;
    logic        stall;
    logic        inst_valid;
    logic        unused_addr_bits;

    logic [31:0] mem_q [2**AW];

    // With zero wait states the RAM is read on the acceptance edge, so the live PC is used.
    assign rd_addr = (state_q == S_IDLE) ? bus.pc_i : addr_q;
    assign rd_idx  = rd_addr[AW+1:2];
    assign wr_idx  = bus.waddr_i[AW+1:2];

    assign unused_addr_bits = ^{bus.pc_i[31:AW+2], bus.pc_i[1:0],
                                bus.waddr_i[31:AW+2], bus.waddr_i[1:0]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        load_addr  = 1'b0;
        enter_resp = 1'b0;
        stall      = 1'b0;
        inst_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                stall = bus.req_i;
                if (bus.req_i) begin
                    load_addr = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (cnt_q == 3'd0) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_RESP: begin
                inst_valid = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A taken jump overrides everything, including a request in the same cycle.
        if (bus.flush_i) begin
            state_d    = S_IDLE;
            cnt_d      = 3'd0;
            load_addr  = 1'b0;
            enter_resp = 1'b0;
            stall      = 1'b0;
            inst_valid = 1'b0;
        end
    end

`ifdef IFETCH_MISALIGN_CHK_EN
    logic misalign_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            addr_q      <= 32'd0;
            inst_q      <= NOP_INST;
            inst_addr_q <= 32'd0;
`ifdef IFETCH_MISALIGN_CHK_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load_addr) begin
                addr_q <= bus.pc_i;
            end
            if (enter_resp) begin
                inst_addr_q <= rd_addr;
`ifdef IFETCH_MISALIGN_CHK_EN
                misalign_q  <= (rd_addr[1:0] != 2'b00);
                inst_q      <= (rd_addr[1:0] != 2'b00) ? NOP_INST : mem_q[rd_idx];
`else
                inst_q      <= mem_q[rd_idx];
`endif
            end
        end
    end

    // Program-load port: independent of reset so preload can overlap it.
    always_ff @(posedge clk) begin
        if (bus.we_i) begin
            mem_q[wr_idx] <= bus.wdata_i;
        end
    end

    assign bus.inst_o       = inst_q;
    assign bus.inst_addr_o  = inst_addr_q;
    assign bus.inst_valid_o = inst_valid;
    assign bus.stall_o      = stall;
`ifdef IFETCH_MISALIGN_CHK_EN
    assign bus.misalign_o   = misalign_q & inst_valid;
`endif

endmodule

// File: tb/tb_ifetch_resp.sv
// Bench for ifetch_resp: one instance with two wait states, one with none, sharing a clock.
// Responses are checked against a scoreboard queue fed when requests are driven.
module tb_ifetch_resp;
    localparam logic [31:0] NOP = 32'h00000013;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ifetch_resp_if bus2();
    ifetch_resp_if bus0();

    ifetch_resp #(.AW(10), .WAIT_CYCLES(2), .NOP_INST(NOP)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2.slave)
    );
    ifetch_resp #(.AW(10), .WAIT_CYCLES(0), .NOP_INST(NOP)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
        logic        mis;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        mis;
    } vec_t;

    exp_t        q2[$];
    exp_t        q0[$];
    vec_t        vecs[8];
    logic [31:0] mdl [1024];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus2.inst_valid_o === 1'b1) begin
            if (q2.size() == 0) begin
                chk("dut2_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = q2.pop_front();
                chk("dut2_inst", bus2.inst_o, e.inst);
                chk("dut2_addr", bus2.inst_addr_o, e.addr);
`ifdef IFETCH_MISALIGN_CHK_EN
                chk("dut2_misalign", 32'(bus2.misalign_o), 32'(e.mis));
`endif
            end
        end
        if (bus0.inst_valid_o === 1'b1) begin
            if (q0.size() == 0) begin
                chk("dut0_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                chk("dut0_inst", bus0.inst_o, e.inst);
                chk("dut0_addr", bus0.inst_addr_o, e.addr);
`ifdef IFETCH_MISALIGN_CHK_EN
                chk("dut0_misalign", 32'(bus0.misalign_o), 32'(e.mis));
`endif
            end
        end
    end

    task automatic push2(input logic [31:0] a, input logic [31:0] d, input logic m);
        exp_t e;
        e.addr = a;
        e.inst = d;
        e.mis  = m;
        q2.push_back(e);
    endtask

    task automatic push0(input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.addr = a;
        e.inst = d;
        e.mis  = 1'b0;
        q0.push_back(e);
    endtask

    task automatic set_we(input logic en, input int w, input logic [31:0] d);
        bus2.we_i    = en;
        bus2.waddr_i = 32'(w) << 2;
        bus2.wdata_i = d;
        bus0.we_i    = en;
        bus0.waddr_i = 32'(w) << 2;
        bus0.wdata_i = d;
    endtask

    task automatic wait_valid2(input string tag, output int n);
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (bus2.inst_valid_o === 1'b1) seen = 1'b1;
        end
        if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // One fetch on the two-wait-state instance, checking stall and latency along the way.
    task automatic fetch2(input logic [31:0] pc, input logic [31:0] ei, input logic em,
                          input string tag);
        int  n;
        bit  seen;
        @(posedge clk); #1;
        bus2.req_i = 1'b1;
        bus2.pc_i  = pc;
        push2(pc, ei, em);
        @(negedge clk);
        chk({tag, "_stall_req"}, 32'(bus2.stall_o), 32'd1);
        @(posedge clk); #1;
        bus2.req_i = 1'b0;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (bus2.inst_valid_o === 1'b1) seen = 1'b1;
            else chk({tag, "_stall_wait"}, 32'(bus2.stall_o), 32'd1);
        end
        chk({tag, "_latency"}, 32'(n), 32'd3);
        chk({tag, "_stall_resp"}, 32'(bus2.stall_o), 32'd0);
    endtask

    initial begin
        int   n;
        logic st;
        logic [31:0] pc;

        rst = 1'b1;
        bus2.req_i = 1'b1; bus2.pc_i = 32'h10; bus2.flush_i = 1'b0;
        bus0.req_i = 1'b1; bus0.pc_i = 32'h10; bus0.flush_i = 1'b0;
        set_we(1'b0, 0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus2.req_i = 1'b0;
        bus0.req_i = 1'b0;
        @(negedge clk);
        chk("rst_inst2", bus2.inst_o, NOP);
        chk("rst_addr2", bus2.inst_addr_o, 32'd0);
        chk("rst_valid2", 32'(bus2.inst_valid_o), 32'd0);
        chk("rst_inst0", bus0.inst_o, NOP);
        chk("rst_addr0", bus0.inst_addr_o, 32'd0);
        chk("rst_stall0_noreq", 32'(bus0.stall_o), 32'd0);
`ifdef IFETCH_MISALIGN_CHK_EN
        chk("rst_misalign2", 32'(bus2.misalign_o), 32'd0);
`endif

        for (int w = 0; w < 32; w++) begin
            logic [31:0] d;
            d = (w == 4) ? 32'hDEADBEEF : {8'(w), 8'hA5, 8'(w * 3), 8'h5A};
            @(posedge clk); #1;
            set_we(1'b1, w, d);
            mdl[w] = d;
        end
        @(posedge clk); #1;
        set_we(1'b0, 0, 32'd0);

        vecs[0] = '{32'h00000010, mdl[4],  1'b0};
        vecs[1] = '{32'h00000000, mdl[0],  1'b0};
        vecs[2] = '{32'h00001004, mdl[1],  1'b0};
        vecs[3] = '{32'h0000007C, mdl[31], 1'b0};
        vecs[4] = '{32'hFFFFF008, mdl[2],  1'b0};
        vecs[5] = '{32'h00000044, mdl[17], 1'b0};
`ifdef IFETCH_MISALIGN_CHK_EN
        vecs[6] = '{32'h00000006, NOP,     1'b1};
`else
        vecs[6] = '{32'h00000006, mdl[1],  1'b0};
`endif
        vecs[7] = '{32'h00000008, mdl[2],  1'b0};
        for (int i = 0; i < 8; i++) begin
            fetch2(vecs[i].pc, vecs[i].inst, vecs[i].mis, $sformatf("vec%0d", i));
        end

        // Zero wait states, PC advancing whenever stall is low.
        push0(32'h0, mdl[0]);
        push0(32'h4, mdl[1]);
        push0(32'h8, mdl[2]);
        pc = 32'h0;
        @(posedge clk); #1;
        bus0.req_i = 1'b1;
        bus0.pc_i  = pc;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            st = bus0.stall_o;
            chk($sformatf("w0_valid_c%0d", i), 32'(bus0.inst_valid_o), 32'(i % 2));
            @(posedge clk); #1;
            if (!st) pc = pc + 32'd4;
            bus0.pc_i = pc;
            if (i == 5) bus0.req_i = 1'b0;
        end

        // Flush during the first wait cycle drops the fetch.
        @(posedge clk); #1;
        bus2.req_i = 1'b1;
        bus2.pc_i  = 32'h20;
        @(posedge clk); #1;
        bus2.req_i   = 1'b0;
        bus2.flush_i = 1'b1;
        @(negedge clk);
        chk("flush_stall", 32'(bus2.stall_o), 32'd0);
        chk("flush_valid", 32'(bus2.inst_valid_o), 32'd0);
        @(posedge clk); #1;
        bus2.flush_i = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("flush_no_valid", 32'(bus2.inst_valid_o), 32'd0);
        end
        fetch2(32'h40, mdl[16], 1'b0, "post_flush");

        // Request alongside flush in IDLE is ignored.
        @(posedge clk); #1;
        bus2.req_i   = 1'b1;
        bus2.flush_i = 1'b1;
        bus2.pc_i    = 32'h10;
        @(negedge clk);
        chk("flush_idle_stall", 32'(bus2.stall_o), 32'd0);
        @(posedge clk); #1;
        bus2.req_i   = 1'b0;
        bus2.flush_i = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("flush_idle_no_valid", 32'(bus2.inst_valid_o), 32'd0);
        end

        // Reset mid-fetch, with a RAM write landing during reset.
        @(posedge clk); #1;
        bus2.req_i = 1'b1;
        bus2.pc_i  = 32'h10;
        @(posedge clk); #1;
        bus2.req_i = 1'b0;
        rst = 1'b1;
        set_we(1'b1, 20, 32'hCAFEF00D);
        mdl[20] = 32'hCAFEF00D;
        @(posedge clk); #1;
        rst = 1'b0;
        set_we(1'b0, 0, 32'd0);
        @(negedge clk);
        chk("midrst_inst", bus2.inst_o, NOP);
        chk("midrst_addr", bus2.inst_addr_o, 32'd0);
        repeat (5) begin
            @(negedge clk);
            chk("midrst_no_valid", 32'(bus2.inst_valid_o), 32'd0);
        end
        fetch2(32'h50, mdl[20], 1'b0, "write_in_reset");

        // Write to the word being read on the RESP-entry edge: old data comes back.
        @(posedge clk); #1;
        bus2.req_i = 1'b1;
        bus2.pc_i  = 32'h4;
        push2(32'h4, mdl[1], 1'b0);
        @(posedge clk); #1;
        bus2.req_i = 1'b0;
        @(posedge clk); #1;
        set_we(1'b1, 1, 32'h12345678);
        @(posedge clk); #1;
        set_we(1'b0, 0, 32'd0);
        mdl[1] = 32'h12345678;
        wait_valid2("rbw", n);
        fetch2(32'h4, 32'h12345678, 1'b0, "rbw_refetch");

`ifdef IFETCH_MISALIGN_CHK_EN
        @(negedge clk);
        chk("misalign_idle", 32'(bus2.misalign_o), 32'd0);
`endif

        repeat (5) @(negedge clk);
        chk("q2_drained", 32'(q2.size()), 32'd0);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
